// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the execute-stage multiply/divide unit:
//   operand width, mul/div op encodings, FSM state encoding and small
//   op-decode helpers.
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Operand width. The mul/div unit is written for 32 bits only.
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // bit 1 of the encoding selects divide, bit 0 selects unsigned
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/pipe_md_step.sv
// ---------------------------------------------------------------------------
// pipe_md_step
//   One iteration of the iterative multiply/divide datapath (pure
//   combinational).
//
//   Multiply (shift-add): acc = {partial product high, multiplier bits}.
//     If acc[0] is set the multiplicand is added into the high half, then
//     the whole 65-bit result shifts right by one.
//   Divide (restoring): acc = {partial remainder, dividend/quotient bits}.
//     The remainder is shifted left taking the next dividend bit, the
//     divisor is trial-subtracted, and the quotient bit shifts in at bit 0.
//
// Ports
//   acc     in  2*XLEN  current accumulator
//   opnd    in  XLEN    multiplicand magnitude (mul) or divisor magnitude (div)
//   is_div  in  1       1 = restoring divide step, 0 = shift-add step
//   acc_nxt out 2*XLEN  accumulator after this iteration
// ---------------------------------------------------------------------------
module pipe_md_step
  import pipe_pkg::*;
(
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_nxt
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] trial;
  logic            fits;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    rem_sh = acc[2*XLEN-1:XLEN-1];
    trial  = {1'b0, rem_sh} - {2'b00, opnd};
    // Remainder before the shift is below the divisor, so a successful
    // subtract always leaves a value that fits in XLEN bits; any bit set
    // above that means the divisor did not fit.
    fits   = (trial[XLEN+1:XLEN] == 2'b00);
    acc_nxt = '0;
    if (is_div) begin
      if (fits) acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else      acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pipe_muldiv.sv
// ---------------------------------------------------------------------------
// pipe_muldiv
//   Iterative MULT/MULTU/DIV/DIVU unit for the execute stage. Operands are
//   taken as magnitudes at the start edge, 32 shift-add / restoring-divide
//   iterations run in RUN, and FIX applies sign correction and writes the
//   architectural HI/LO registers. HI/LO are untouched until FIX.
//   A stall is requested while busy and another mul/div, mfhi/mflo or
//   mthi/mtlo is in E.
//
//   Build option: PIPE_MULDIV_DIV_EN
//     defined   - DIV/DIVU supported.
//     undefined - no divide datapath; DIV/DIVU in IDLE are ignored.
//
// Ports
//   clk       in   1     pipeline clock
//   clrn      in   1     asynchronous active-low reset
//   ea        in   XLEN  operand A (multiplicand / dividend / mthi-mtlo data)
//   eb        in   XLEN  operand B (multiplier / divisor)
//   estart    in   1     mul/div instruction in E
//   eop       in   2     MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   ehilo_rd  in   1     mfhi/mflo in E
//   ewhi      in   1     mthi in E
//   ewlo      in   1     mtlo in E
//   hi, lo    out  XLEN  architectural HI/LO
//   busy      out  1     operation in progress (registered)
//   stall     out  1     busy & (estart | ehilo_rd | ewhi | ewlo)
// ---------------------------------------------------------------------------
module pipe_muldiv
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            clrn,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic            estart,
  input  logic [1:0]      eop,
  input  logic            ehilo_rd,
  input  logic            ewhi,
  input  logic            ewlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall
);

`ifdef PIPE_MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif

  md_state_e         state, state_nxt;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  logic              op_div, neg_res, neg_rem, dz;

  logic              in_div, start_ok;
  logic              load, step, fix, wr_hi, wr_lo;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return -v;
  endfunction

  // Without the divide datapath a DIV/DIVU never leaves IDLE.
  always_comb begin
    in_div   = DIV_EN & md_is_div(md_op_e'(eop));
    start_ok = estart & (DIV_EN | ~md_is_div(md_op_e'(eop)));
    a_neg    = md_is_signed(md_op_e'(eop)) & ea[XLEN-1];
    b_neg    = md_is_signed(md_op_e'(eop)) & eb[XLEN-1];
    a_mag    = a_neg ? neg_w(ea) : ea;
    b_mag    = b_neg ? neg_w(eb) : eb;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (count == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. A mul/div start in the same cycle as mthi/mtlo takes
  // priority and the HI/LO writes are dropped.
  always_comb begin
    load  = (state == IDLE) & start_ok;
    step  = (state == RUN);
    fix   = (state == FIX);
    wr_hi = (state == IDLE) & ewhi & ~estart;
    wr_lo = (state == IDLE) & ewlo & ~estart;
  end

  assign stall = busy & (estart | ehilo_rd | ewhi | ewlo);

  pipe_md_step u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (op_div),
    .acc_nxt (acc_nxt)
  );

  // Sign correction applied in FIX. Divide by zero forces an all-ones
  // quotient; the unsigned restoring loop already leaves the dividend
  // magnitude as remainder, which the dividend-sign rule turns back into
  // the original dividend.
  always_comb begin
    prod = neg_res ? neg_dw(acc) : acc;
    quot = dz ? '1 : (neg_res ? neg_w(acc[XLEN-1:0]) : acc[XLEN-1:0]);
    rem  = neg_rem ? neg_w(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
  end

  // Datapath: accumulator, latched operand/flags, iteration count, HI/LO
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      acc     <= '0;
      opnd    <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (load) begin
        acc     <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
        opnd    <= in_div ? b_mag : a_mag;
        op_div  <= in_div;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        dz      <= in_div & (eb == '0);
        count   <= '0;
      end else if (step) begin
        acc   <= acc_nxt;
        count <= count + 5'd1;
      end

      if (fix) begin
        if (op_div) begin
          hi <= rem;
          lo <= quot;
        end else begin
          hi <= prod[2*XLEN-1:XLEN];
          lo <= prod[XLEN-1:0];
        end
      end else begin
        if (wr_hi) hi <= ea;
        if (wr_lo) lo <= ea;
      end
    end
  end

endmodule

// File: doc/pipe_muldiv.md
# pipe_muldiv

Iterative multiply/divide unit for the execute stage of the 5-stage pipeline. Consumes the E-stage operands `ea`/`eb` and control bits produced by the ID/EX pipeline register. Runs MULT/MULTU/DIV/DIVU over multiple cycles into private HI/LO registers. Drives a stall request back to pipeline control while an HI/LO consumer or a second mul/div op reaches E before the current op is done.

## Interface
- `XLEN`, 32, operand width; only 32 is supported.
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `clrn`  in  1  reset, asynchronous, active-low.
- `ea`  in  32  operand A (multiplicand/dividend, also mthi/mtlo data).
- `eb`  in  32  operand B (multiplier/divisor).
- `estart`  in  1  a mul/div instruction is in E this cycle.
- `eop`  in  2  operation: MULT, MULTU, DIV, DIVU.
- `ehilo_rd`  in  1  mfhi/mflo is in E this cycle.
- `ewhi`, `ewlo`  in  1 each  mthi/mtlo is in E this cycle.
- `hi`, `lo`  out  32 each  architectural HI/LO registers.
- `busy`  out  1  an operation is in progress (registered).
- `stall`  out  1  combinational: `busy & (estart | ehilo_rd | ewhi | ewlo)`.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE**
  - `estart` latches operand magnitudes, sign flags, op and count=0, then goes to RUN.
  - `ewhi`/`ewlo` write `ea` into HI/LO. If both are set in the same cycle, both are written.
  - `estart` together with `ewhi`/`ewlo`: the mul/div op wins and mthi/mtlo are ignored. This is illegal for a compiler; a bench flags it as a warning.
- **RUN**
  - One iteration per cycle, 32 iterations, count 0..31. Count reaching 31 moves to FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring divide. 33-bit trial subtract of the divisor from the partial remainder; the quotient bit shifts in.
  - `estart`, `ewhi` and `ewlo` are ignored. Pipeline control holds them via `stall`.
- **FIX**
  - Applies sign correction, writes HI/LO, returns to IDLE.
- Signed rules:
  - Operands are converted to magnitudes.
  - Product is negated (64-bit) if the signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- MULT/MULTU: {HI,LO} = 64-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero is not trapped: LO = 32'hFFFF_FFFF, HI = dividend (original signed value for DIV).
- DIV 32'h8000_0000 / -1: LO = 32'h8000_0000, HI = 0. No exception.
- `hi`/`lo` are not modified in RUN. Intermediate values live in separate accumulator registers.

## Timing
- Reset: state=IDLE, count=0, `busy`=0, `hi`=0, `lo`=0, all accumulators 0. `stall`=0 follows combinationally.
- Reset asserted mid-operation aborts immediately. HI/LO read 0 and no partial result is written.
- Latency: the start edge is E0. Edges E1..E32 are iterations, and E32 also enters FIX. Edge E33 writes HI/LO.
- `busy` is high from after E0 through E33 (33 cycles).
- An `estart` sampled at E0 never stalls itself; `stall` uses registered `busy`.
- Back-to-back: a second `estart` on the cycle after E33 is accepted normally.
- An mfhi after E33 sees the new value. An mfhi held by `stall` is released in the cycle after E33.

## Configuration
- `PIPE_MULDIV_DIV_EN`
  - Defined: DIV/DIVU are supported as above.
  - Undefined: the divide datapath is not built. DIV/DIVU in IDLE is a no-op: no state change, `busy` stays 0, HI/LO unchanged. MULT/MULTU are unaffected.

## Structure
- Shared package `pipe_pkg`:
  - Op encodings: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - State enum: IDLE/RUN/FIX.
  - `XLEN` constant.
- One combinational sub-module, `pipe_md_step`: a single shift-add / trial-subtract iteration. Inputs are the accumulator, operand and op class; outputs are the next accumulator.
- The FSM, counter and HI/LO registers stay in `pipe_muldiv`.

## Test plan
- MULTU ea=32'hFFFF_FFFF, eb=32'hFFFF_FFFF → after E33, HI=32'hFFFF_FFFE, LO=32'h0000_0001; `busy` high exactly 33 cycles.
- MULT ea=-3, eb=7 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIV ea=-7, eb=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- DIVU ea=5, eb=0 → LO=32'hFFFF_FFFF, HI=5.
- DIV 32'h8000_0000 / -1 → LO=32'h8000_0000, HI=0.
- Hazards: MULT 6×7 then `ehilo_rd` at E5 → `stall` high E5..E33, then LO=42. An `estart` or `ewhi` during RUN → `stall`=1 and HI/LO not corrupted.
- `clrn` low at E10 of a DIVU → `busy`=0, HI=LO=0 immediately. Without `PIPE_MULDIV_DIV_EN`, DIV never asserts `busy`.
